// File: rtl/mem_arb_pkg.sv
// Shared types and requester IDs for the memory-port arbiter.
// Configuration macro: MEM_ARB_RR_EN (round-robin tie-break, used in arb_pick).
package mem_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   localparam logic REQ_IF = 1'b0;
   localparam logic REQ_D  = 1'b1;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection between fetch and data requesters.
// Configuration macro: MEM_ARB_RR_EN selects round-robin ties; default is data-over-fetch.
module arb_pick
   import mem_arb_pkg::*;
(
   input  logic i_if_req,
   input  logic i_d_req,
   input  logic i_last,
   output logic o_any,
   output logic o_win
);

   assign o_any = i_if_req | i_d_req;

`ifdef MEM_ARB_RR_EN
   // On a tie grant whoever did not win last time
   always_comb begin
      o_win = REQ_IF;
      if (i_if_req && i_d_req) o_win = ~i_last;
      else if (i_d_req)        o_win = REQ_D;
   end
`else
   logic w_unused_last;
   assign w_unused_last = i_last;
   assign o_win         = i_d_req ? REQ_D : REQ_IF;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store requesters,
// with req/gnt handshake, registered memory payload, one-cycle response pulse
// and an ack timeout that reports an error.
// Configuration macro: MEM_ARB_RR_EN (round-robin arbitration with last-winner register).
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_gnt,
   output logic                if_rvalid,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_err,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [DATA_W/8-1:0] d_be,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   output logic                d_gnt,
   output logic                d_rvalid,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_err,
   output logic                mem_req,
   output logic                mem_we,
   output logic [DATA_W/8-1:0] mem_be,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic                mem_ack,
   input  logic [DATA_W-1:0]   mem_rdata
);

   localparam int unsigned BE_W  = DATA_W / 8;
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   arb_state_t        r_state;
   logic              r_owner;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_mem_req;
   logic              r_mem_we;
   logic [BE_W-1:0]   r_mem_be;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic              r_if_rvalid;
   logic [DATA_W-1:0] r_if_rdata;
   logic              r_if_err;
   logic              r_d_rvalid;
   logic [DATA_W-1:0] r_d_rdata;
   logic              r_d_err;

   logic              w_any;
   logic              w_win;
   logic              w_last;
   logic              w_grant;
   logic              w_done;
   logic [DATA_W-1:0] w_rsp_data;
   logic              w_rsp_err;

   arb_pick u_pick (
      .i_if_req (if_req),
      .i_d_req  (d_req),
      .i_last   (w_last),
      .o_any    (w_any),
      .o_win    (w_win)
   );

   assign w_grant    = (r_state == IDLE) && w_any;
   assign w_done     = (r_state == BUSY) && (mem_ack || (r_cnt == CNT_LAST));
   assign w_rsp_err  = ~mem_ack;
   assign w_rsp_data = (mem_ack && !r_mem_we) ? mem_rdata : '0;

`ifdef MEM_ARB_RR_EN
   logic r_last;
   // Remember the most recent winner for round-robin ties
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         r_last <= REQ_IF;
      else if (w_grant) r_last <= w_win;
   end
   assign w_last = r_last;
`else
   assign w_last = REQ_IF;
`endif

   // Access FSM: latch winner payload, wait for ack or timeout, pulse response
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_owner     <= REQ_IF;
         r_cnt       <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_be    <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_if_rvalid <= 1'b0;
         r_if_rdata  <= '0;
         r_if_err    <= 1'b0;
         r_d_rvalid  <= 1'b0;
         r_d_rdata   <= '0;
         r_d_err     <= 1'b0;
      end else begin
         r_if_rvalid <= 1'b0;
         r_d_rvalid  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_grant) begin
                  r_state   <= BUSY;
                  r_mem_req <= 1'b1;
                  r_owner   <= w_win;
                  r_cnt     <= '0;
                  if (w_win == REQ_D) begin
                     r_mem_we    <= d_we;
                     r_mem_be    <= d_be;
                     r_mem_addr  <= d_addr;
                     r_mem_wdata <= d_wdata;
                  end else begin
                     r_mem_we    <= 1'b0;
                     r_mem_be    <= '1;
                     r_mem_addr  <= if_addr;
                     r_mem_wdata <= '0;
                  end
               end
            end
            BUSY: begin
               if (w_done) begin
                  r_state   <= IDLE;
                  r_mem_req <= 1'b0;
                  if (r_owner == REQ_D) begin
                     r_d_rvalid <= 1'b1;
                     r_d_rdata  <= w_rsp_data;
                     r_d_err    <= w_rsp_err;
                  end else begin
                     r_if_rvalid <= 1'b1;
                     r_if_rdata  <= w_rsp_data;
                     r_if_err    <= w_rsp_err;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign if_gnt    = w_grant && (w_win == REQ_IF);
   assign d_gnt     = w_grant && (w_win == REQ_D);
   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_be    = r_mem_be;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign if_rvalid = r_if_rvalid;
   assign if_rdata  = r_if_rdata;
   assign if_err    = r_if_err;
   assign d_rvalid  = r_d_rvalid;
   assign d_rdata   = r_d_rdata;
   assign d_err     = r_d_err;

endmodule
